divisor_secuencial_8x4: RTL and testbench
=========================================

Name: divisor_secuencial_8x4

Overview:
Sequential unsigned restoring divider: 8-bit dividend / 4-bit divisor -> 8-bit quotient, 4-bit remainder. It is the inverse datapath of the team's 4x4 combinational multiplier core, and lets the same Tiny Tapeout tile check a product back against its operands. It produces one quotient bit per clock and uses a start/busy/done handshake so a top-level wrapper can drive it from ui_in/uio pins.

Parameters:
DIVIDEND_W, 8, dividend and quotient width; sets the iteration count.
DIVISOR_W, 4, divisor and remainder width.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
dividend  input  DIVIDEND_W  unsigned dividend; captured when start is accepted
divisor  input  DIVISOR_W  unsigned divisor; captured when start is accepted
quotient  output  DIVIDEND_W  registered result
remainder  output  DIVISOR_W  registered result
busy  output  1  high while iterating
done  output  1  one-cycle pulse when results become valid
div_by_zero  output  1  registered flag for the last accepted operation

Behaviour:
- Reset (async assert, sync release): state=IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; internal iteration counter=0.
- States: IDLE, CALC, DONE.
- IDLE/DONE + start=1 and divisor!=0:
  - capture operands;
  - partial remainder register (DIVISOR_W+1 bits) = 0;
  - counter = DIVIDEND_W-1;
  - go to CALC; busy=1 from the next cycle.
- IDLE/DONE + start=1 and divisor==0:
  - no CALC;
  - next cycle: state DONE, quotient=all ones (8'hFF), remainder=0, div_by_zero=1, done=1.
- CALC, each cycle:
  - shift the partial remainder left, bringing in the next dividend bit (MSB first);
  - if partial >= divisor: subtract, quotient bit=1; else quotient bit=0;
  - decrement the counter;
  - after the iteration at counter 0: go to DONE.
- CALC runs exactly DIVIDEND_W cycles.
- Latency: start sampled at edge T -> busy high for edges T+1..T+8; done=1 and results valid in the cycle after edge T+9.
- DONE:
  - done=1 for exactly one cycle, then 0 while remaining in DONE;
  - quotient, remainder and div_by_zero hold until the next accepted start;
  - div_by_zero is cleared on any accepted start with divisor!=0.
- Partial results never appear on quotient or remainder; those outputs update only on entry to DONE.
- start while busy=1: ignored; operands are not re-captured and the operation is not restarted.
- start held high continuously: a new operation is accepted in the DONE cycle, so back-to-back operations are 10 cycles apart.
- Reset asserted mid-CALC: immediate return to reset values; no done pulse.
- Invariant: quotient*divisor + remainder == dividend and remainder < divisor, whenever div_by_zero=0.

Optional Feature:
DIV_EARLY_EXIT_EN
- Defined:
  - start accepted with divisor!=0 and dividend < divisor skips CALC;
  - next cycle: DONE with quotient=0, remainder=dividend[DIVISOR_W-1:0], done=1 (1-cycle latency, same as divide-by-zero).
- Undefined: such operands take the full DIVIDEND_W-cycle CALC path and give the same numeric result (latency 9).

Test Plan:
1. Reset with rst_n=0 mid-idle -> all outputs 0; state IDLE; busy=0.
2. start, dividend=200, divisor=13 -> busy for 8 cycles; done pulse at T+9; quotient=15, remainder=5, div_by_zero=0.
3. start, dividend=255, divisor=1 -> quotient=255, remainder=0; then dividend=100, divisor=0 -> done at T+1, quotient=8'hFF, remainder=0, div_by_zero=1.
4. start, dividend=7, divisor=9 -> quotient=0, remainder=7; done at T+1 with DIV_EARLY_EXIT_EN, at T+9 without.
5. start, dividend=200, divisor=13; pulse start with dividend=50, divisor=3 at cycle T+4 -> ignored; result is 15 r 5. Then rst_n=0 at T+3 of a new operation -> no done; outputs 0.
6. Exhaustive loop: all 256x15 nonzero operand pairs, back-to-back with start held high -> invariant holds for each; done spacing is 10 cycles.

Source files
------------

// File: rtl/divisor_secuencial_8x4.sv
// divisor_secuencial_8x4: sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_EARLY_EXIT_EN to retire dividend < divisor in one cycle instead of iterating.
`timescale 1ns/1ps
module divisor_secuencial_8x4 #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero
);
    localparam int CW = $clog2(DIVIDEND_W);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  fin_q, fin_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W:0]    part_q, part_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic [DIVISOR_W:0]    shifted;
    logic                  fits, accept;

    // dvd_q shifts the dividend out at the top while quotient bits enter at the bottom
    always_comb begin
        shifted     = {part_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
        fits        = shifted >= {1'b0, dvs_q};
        accept      = start && (state_q != CALC);
        state_d     = state_q;
        cnt_d       = cnt_q;
        fin_d       = fin_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        part_d      = part_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        done_d      = 1'b0;
        busy_d      = (state_q == CALC) && !fin_q;
        if (accept) begin
            state_d = CALC;
            dvs_d   = divisor;
            cnt_d   = CW'(DIVIDEND_W - 1);
            dz_d    = divisor == '0;
            fin_d   = divisor == '0;
            dvd_d   = (divisor == '0) ? '1 : dividend;
            part_d  = '0;
`ifdef DIV_EARLY_EXIT_EN
            if (divisor != '0 && DIVIDEND_W'(divisor) > dividend) begin
                fin_d  = 1'b1;
                dvd_d  = '0;
                part_d = (DIVISOR_W + 1)'(dividend[DIVISOR_W-1:0]);
            end
`endif
        end else if (state_q == CALC && fin_q) begin
            // zero-divisor and early-exit results retire through this same final slot
            state_d     = DONE;
            fin_d       = 1'b0;
            quotient_d  = dvd_q;
            remainder_d = part_q[DIVISOR_W-1:0];
            done_d      = 1'b1;
        end else if (state_q == CALC) begin
            part_d = fits ? shifted - {1'b0, dvs_q} : shifted;
            dvd_d  = {dvd_q[DIVIDEND_W-2:0], fits};
            cnt_d  = cnt_q - 1'b1;
            fin_d  = cnt_q == '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fin_q       <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            part_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fin_q       <= fin_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            part_q      <= part_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dz_q        <= dz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_q;
endmodule

// File: tb/tb_divisor_secuencial_8x4.sv
// tb_divisor_secuencial_8x4: directed and exhaustive checks of the 8/4 sequential divider.
`timescale 1ns/1ps
module tb_divisor_secuencial_8x4;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy, done, div_by_zero;
    int checks = 0, errors = 0, cyc = 0;
`ifdef DIV_EARLY_EXIT_EN
    localparam int EE = 1;
`else
    localparam int EE = 0;
`endif

    divisor_secuencial_8x4 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_q"}, 32'(quotient), 0);
        chk({tag, "_r"}, 32'(remainder), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_dz"}, 32'(div_by_zero), 0);
    endtask

    // one operation from idle/done: latency, busy length, results, one-cycle done, hold
    task automatic run(input string tag, input int a, input int b, input int lat, input int eq, input int er, input int ez);
        int n, nb;
        dividend = 8'(a);
        divisor  = 4'(b);
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        nb = 0;
        while (done !== 1'b1 && n < 30) begin
            nb += (busy === 1'b1) ? 1 : 0;
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_busy"}, nb, (lat > 1) ? 8 : 0);
        chk({tag, "_q"}, 32'(quotient), eq);
        chk({tag, "_r"}, 32'(remainder), er);
        chk({tag, "_dz"}, 32'(div_by_zero), ez);
        tick();
        chk({tag, "_pulse"}, 32'(done), 0);
        chk({tag, "_hold"}, 32'(quotient), eq);
    endtask

    initial begin
        int n, nd, last, el;
        #3;
        chk_zero("rst0");
        #20 rst_n = 1'b1;
        tick();
        chk_zero("idle");
        run("d200_13", 200, 13, 9, 15, 5, 0);
        run("d255_1", 255, 1, 9, 255, 0, 0);
        run("d100_0", 100, 0, 1, 255, 0, 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_idle");
        #3 rst_n = 1'b1;
        tick();
        run("d7_9", 7, 9, EE ? 1 : 9, 0, 7, 0);
        // start pulse during the iteration must be ignored
        dividend = 8'd200;
        divisor  = 4'd13;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        dividend = 8'd50;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 4;
        while (done !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk("ign_lat", n, 9);
        chk("ign_q", 32'(quotient), 15);
        chk("ign_r", 32'(remainder), 5);
        chk("ign_dz", 32'(div_by_zero), 0);
        // reset mid-iteration
        dividend = 8'd200;
        divisor  = 4'd13;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_calc");
        #2 rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            nd += (done === 1'b1) ? 1 : 0;
        end
        chk("rst_calc_nodone", nd, 0);
        chk("rst_calc_q", 32'(quotient), 0);
        // exhaustive back-to-back with start held high
        last = -1;
        start = 1'b1;
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                dividend = a[7:0];
                divisor  = b[3:0];
                el = (EE == 1 && a < b) ? 1 : 9;
                tick();
                n = 0;
                while (done !== 1'b1 && n < 30) begin
                    tick();
                    n++;
                end
                chk("ex_lat", n, el);
                chk("ex_q", 32'(quotient), a / b);
                chk("ex_r", 32'(remainder), a % b);
                if (last >= 0) chk("ex_spacing", cyc - last, el + 1);
                last = cyc;
            end
        end
        start = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
